i2c_master_rd16: RTL

- I2C master controller that reads and writes 16-bit registers of an ADS1115-style ADC: conversion reg 0x00, config reg 0x01.
- Sits directly upstream of the I2C slave model on the bench, and of the real ADC in the wall-follower design.
- Feeds sensor samples to the PID/control logic.
- Single-transaction command interface; open-drain SCL/SDA.

---
 rtl/i2c_pkg.sv | 8 +
 rtl/i2c_master_rd16_if.sv | 14 +
 rtl/i2c_qtr_tick.sv | 25 ++
 rtl/i2c_master_rd16.sv | 135 +++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM states, ADS1115 register pointers and I2C direction bits
package i2c_pkg;
  typedef enum logic [3:0] {IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_ACK, STOP, DONE} i2c_state_t;
  localparam logic [7:0] ADS_REG_CONV = 8'h00;
  localparam logic [7:0] ADS_REG_CFG = 8'h01;
  localparam logic I2C_RD = 1'b1;
  localparam logic I2C_WR = 1'b0;
endpackage

// File: rtl/i2c_master_rd16_if.sv
// i2c_master_rd16_if: single-transaction command/response bundle of the 16-bit register master
interface i2c_master_rd16_if;
  logic start;
  logic rd_nwr;
  logic [6:0] slave_addr;
  logic [7:0] reg_ptr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic busy;
  logic done;
  logic ack_err;
  modport master (output start, rd_nwr, slave_addr, reg_ptr, wr_data, input rd_data, busy, done, ack_err);
  modport slave (input start, rd_nwr, slave_addr, reg_ptr, wr_data, output rd_data, busy, done, ack_err);
endinterface

// File: rtl/i2c_qtr_tick.sv
// i2c_qtr_tick: enable-gated quarter-SCL-period divider with tick pulse and 2-bit phase
module i2c_qtr_tick #(
  parameter int QTR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       tick,
  output logic [1:0] ph
);
  localparam int W = $clog2(QTR);
  logic [W-1:0] cnt;
  assign tick = en && cnt == W'(QTR - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      ph <= '0;
    end else if (!en) begin
      cnt <= '0;
      ph <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      ph <= ph + 2'(tick);
    end
endmodule

// File: rtl/i2c_master_rd16.sv
// i2c_master_rd16: open-drain I2C master that writes or reads one 16-bit ADS1115-style register
module i2c_master_rd16 import i2c_pkg::*; #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int SCL_FREQ_HZ = 100_000
) (
  input  logic            clk,
  input  logic            rst,
  i2c_master_rd16_if.slave cmd,
  inout  wire             scl,
  inout  wire             sda
);
  localparam int QTR = CLK_FREQ_HZ / (4 * SCL_FREQ_HZ);
  i2c_state_t state, state_n;
  logic [2:0] step, step_n, bit_cnt;
  logic [1:0] ph;
  logic tick, slot_end, sample, busy, rd, nack, ack_err, scl_t, sda_t, scl_low, sda_q, sda_low;
  logic [6:0] addr;
  logic [7:0] ptr, tx_byte;
  logic [15:0] wd, rx_sr, rd_data;
  i2c_qtr_tick #(.QTR(QTR)) u_tick (.clk, .rst, .en(busy), .tick, .ph);
  assign busy = state != IDLE;
  assign slot_end = tick && ph == 2'd3;
  assign sample = tick && ph == 2'd2;
  assign tx_byte = step == 3'd0 ? {addr, I2C_WR} : step == 3'd1 ? ptr :
                   step == 3'd2 ? (rd ? {addr, I2C_RD} : wd[15:8]) : wd[7:0];
  // SDA trails SCL by one extra clock so data never moves on the same edge SCL falls
  assign scl = scl_low ? 1'b0 : 1'bz;
  assign sda = sda_low ? 1'b0 : 1'bz;
  assign cmd.busy = busy;
  assign cmd.done = state == DONE;
  assign cmd.ack_err = ack_err;
  assign cmd.rd_data = rd_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      step <= '0;
    end else begin
      state <= state_n;
      step <= step_n;
    end
  // step: 0 addr+W, 1 pointer, 2 second byte (data hi or addr+R), 3/4 remaining data byte
  always_comb begin
    state_n = state;
    step_n = step;
    scl_t = 1'b0;
    sda_t = 1'b0;
    case (state)
      IDLE: if (cmd.start) begin
        state_n = START;
        step_n = 3'd0;
      end
      START: begin
        scl_t = ph[1];
        sda_t = ph != 2'd0;
        if (slot_end) state_n = TX_BYTE;
      end
      TX_BYTE: begin
        scl_t = !ph[1];
        sda_t = !tx_byte[bit_cnt];
        if (slot_end && bit_cnt == 3'd0) state_n = RX_ACK;
      end
      RX_ACK: begin
        scl_t = !ph[1];
        if (slot_end) begin
          if (nack || (!rd && step == 3'd3)) state_n = STOP;
          else if (rd && step == 3'd1) begin
            state_n = RSTART;
            step_n = 3'd2;
          end else if (rd && step == 3'd2) begin
            state_n = RX_BYTE;
            step_n = 3'd3;
          end else begin
            state_n = TX_BYTE;
            step_n = step + 3'd1;
          end
        end
      end
      RSTART: begin
        scl_t = ph == 2'd0 || ph == 2'd3;
        sda_t = ph[1];
        if (slot_end) state_n = TX_BYTE;
      end
      RX_BYTE: begin
        scl_t = !ph[1];
        if (slot_end && bit_cnt == 3'd0) state_n = TX_ACK;
      end
      TX_ACK: begin
        scl_t = !ph[1];
        sda_t = step == 3'd3;
        if (slot_end) begin
          state_n = step == 3'd3 ? RX_BYTE : STOP;
          step_n = step + 3'd1;
        end
      end
      STOP: begin
        scl_t = !ph[1];
        sda_t = ph != 2'd3;
        if (slot_end) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bit_cnt <= '0;
      rd <= 1'b0;
      addr <= '0;
      ptr <= '0;
      wd <= '0;
      rx_sr <= '0;
      nack <= 1'b0;
      ack_err <= 1'b0;
      rd_data <= '0;
      scl_low <= 1'b0;
      sda_q <= 1'b0;
      sda_low <= 1'b0;
    end else begin
      bit_cnt <= (state == TX_BYTE || state == RX_BYTE) ? bit_cnt - 3'(slot_end) : 3'd7;
      if (state == IDLE && cmd.start) begin
        rd <= cmd.rd_nwr;
        addr <= cmd.slave_addr;
        ptr <= cmd.reg_ptr;
        wd <= cmd.wr_data;
        ack_err <= 1'b0;
      end
      if (state == RX_ACK && sample) nack <= sda;
      if (state == RX_ACK && slot_end && nack) ack_err <= 1'b1;
      if (state == RX_BYTE && sample) rx_sr <= {rx_sr[14:0], sda};
      if (state == STOP && slot_end && rd && !ack_err) rd_data <= rx_sr;
      scl_low <= scl_t;
      sda_q <= sda_t;
      sda_low <= sda_q;
    end
endmodule
